// File: rtl/bcb_tracked.sv
// Branch checkpoint buffer: circular store of checkpoint records with head/tail
// tracking, in-order free at commit, rollback on mispredict restore.

module distram_1rport_1wport #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64,
  parameter int AW    = 3
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Addresses past DEPTH exist only when DEPTH is not a power of two.
  always_comb begin
    rdata = '0;
    if ({1'b0, raddr} < (AW+1)'(DEPTH)) rdata = mem[raddr];
  end
endmodule

module bcb_tracked #(
  parameter  int ENTRIES    = 8,
  parameter  int INFO_WIDTH = 64,
  localparam int IDX_W      = $clog2(ENTRIES),
  localparam int CNT_W      = $clog2(ENTRIES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  save_valid,
  input  logic [INFO_WIDTH-1:0] save_info,
  output logic                  save_ready,
  output logic [IDX_W-1:0]      save_index,
  input  logic                  restore_valid,
  input  logic [IDX_W-1:0]      restore_index,
  output logic [INFO_WIDTH-1:0] restore_info,
  input  logic                  free_valid,
  output logic [IDX_W-1:0]      free_index,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  empty,
  output logic                  full,
  output logic                  error
);
  localparam logic [IDX_W:0] ENT_E = (IDX_W+1)'(ENTRIES);

  logic [IDX_W-1:0] head, tail, head_n, tail_n;
  logic [CNT_W-1:0] occ, occ_n;
  logic             error_r;

  logic             save_acc, free_ok, restore_ok, restore_live, err_set;
  logic [IDX_W:0]   ri_e, head_e, occ_e, offset, rest_cnt;

  function automatic logic [IDX_W-1:0] inc_ptr(input logic [IDX_W-1:0] p);
    if (p == IDX_W'(ENTRIES - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty      = (occ == '0);
  assign full       = (occ == CNT_W'(ENTRIES));
  assign occupancy  = occ;
  assign save_index = tail;
  assign free_index = head;
  assign error      = error_r;

  // Handshake: a save transfers when save_valid & save_ready in a cycle with no
  // restore_valid; save_ready is ~full from registered state only, never from
  // same-cycle free_valid or restore_valid. free_valid and restore_valid have
  // no ready and are always consumed (flagged in error when illegal).
  assign save_ready = ~full;

  // Liveness: distance from head to restore_index (mod ENTRIES) below occupancy.
  always_comb begin
    ri_e   = {1'b0, restore_index};
    head_e = {1'b0, head};
    occ_e  = (IDX_W+1)'(occ);
    if (restore_index >= head) offset = ri_e - head_e;
    else                       offset = ri_e + ENT_E - head_e;
    restore_live = (ri_e < ENT_E) && (offset < occ_e);
  end

  always_comb begin
    save_acc   = save_valid & ~full & ~restore_valid;
    free_ok    = free_valid & ~empty;
    restore_ok = restore_valid & restore_live;
    err_set    = (save_valid & full & ~restore_valid)
               | (free_valid & empty)
               | (restore_valid & ~restore_live);

    head_n   = free_ok ? inc_ptr(head) : head;
    tail_n   = tail;
    occ_n    = occ;
    rest_cnt = offset + 1'b1 - (IDX_W+1)'(free_ok);

    if (restore_ok) begin
      // Everything younger than restore_index is dropped; a free the same
      // cycle still retires the head, possibly leaving the buffer empty.
      tail_n = inc_ptr(restore_index);
      occ_n  = CNT_W'(rest_cnt);
    end else begin
      if (save_acc) tail_n = inc_ptr(tail);
      occ_n = occ + CNT_W'(save_acc) - CNT_W'(free_ok);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
      error_r <= 1'b0;
    end else begin
      head    <= head_n;
      tail    <= tail_n;
      occ     <= occ_n;
      error_r <= error_r | err_set;
    end
  end

  distram_1rport_1wport #(
    .DEPTH (ENTRIES),
    .WIDTH (INFO_WIDTH),
    .AW    (IDX_W)
  ) u_store (
    .CLK   (CLK),
    .we    (save_acc & ~RST),
    .waddr (tail),
    .wdata (save_info),
    .raddr (restore_index),
    .rdata (restore_info)
  );
endmodule

// File: tb/tb_bcb_tracked.sv
// Randomized plus directed bench for bcb_tracked (ENTRIES=6, INFO_WIDTH=8),
// checked against a queue-of-live-indices reference model via a scoreboard.

module tb_bcb_tracked;
  localparam int N = 6;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         save_valid = 1'b0;
  logic [W-1:0] save_info = '0;
  logic         save_ready;
  logic [2:0]   save_index;
  logic         restore_valid = 1'b0;
  logic [2:0]   restore_index = '0;
  logic [W-1:0] restore_info;
  logic         free_valid = 1'b0;
  logic [2:0]   free_index;
  logic [2:0]   occupancy;
  logic         empty, full, error;

  bcb_tracked #(.ENTRIES(N), .INFO_WIDTH(W)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .save_valid    (save_valid),
    .save_info     (save_info),
    .save_ready    (save_ready),
    .save_index    (save_index),
    .restore_valid (restore_valid),
    .restore_index (restore_index),
    .restore_info  (restore_info),
    .free_valid    (free_valid),
    .free_index    (free_index),
    .occupancy     (occupancy),
    .empty         (empty),
    .full          (full),
    .error         (error)
  );

  // ---- clock ----
  always #5 CLK = ~CLK;

  // ---- reference model: ordered list of live indices, oldest first ----
  int         live_q[$];
  int         nxt;
  logic [W-1:0] mem_m [N];
  bit         seen [N];
  bit         err_m;

  int checks = 0;
  int errors = 0;

  // [21] info known, [20:13] info, [12] ready, [11:9] save_index,
  // [8:6] free_index, [5:3] occupancy, [2] empty, [1] full, [0] error
  logic [21:0] exp_q[$];

  function automatic int inc_m(int p);
    return (p == N - 1) ? 0 : p + 1;
  endfunction

  function automatic logic [21:0] snapshot(int ri);
    logic [21:0] e;
    int n;
    n = live_q.size();
    e = '0;
    e[21]    = seen[ri];
    e[20:13] = mem_m[ri];
    e[12]    = (n != N);
    e[11:9]  = 3'(nxt);
    e[8:6]   = 3'((n != 0) ? live_q[0] : nxt);
    e[5:3]   = 3'(n);
    e[2]     = (n == 0);
    e[1]     = (n == N);
    e[0]     = err_m;
    return e;
  endfunction

  task automatic model_reset();
    live_q.delete();
    nxt   = 0;
    err_m = 1'b0;
  endtask

  task automatic model_step(input bit sv, input logic [W-1:0] si, input bit rv,
                            input int ri, input bit fv);
    int pos;
    bit was_empty, was_full;
    was_empty = (live_q.size() == 0);
    was_full  = (live_q.size() == N);
    pos = -1;
    foreach (live_q[i]) if (live_q[i] == ri) pos = i;
    if (rv) begin
      if (pos >= 0) begin
        while (live_q.size() > pos + 1) void'(live_q.pop_back());
        nxt = inc_m(ri);
      end else err_m = 1'b1;
    end else if (sv) begin
      if (was_full) err_m = 1'b1;
      else begin
        mem_m[nxt] = si;
        seen[nxt]  = 1'b1;
        live_q.push_back(nxt);
        nxt = inc_m(nxt);
      end
    end
    if (fv) begin
      if (was_empty) err_m = 1'b1;
      else void'(live_q.pop_front());
    end
  endtask

  // ---- driver ----
  task automatic step(input bit rst, input bit sv, input logic [W-1:0] si,
                      input bit rv, input int ri, input bit fv);
    @(posedge CLK);
    #1;
    RST           = rst;
    save_valid    = sv;
    save_info     = si;
    restore_valid = rv;
    restore_index = 3'(ri);
    free_valid    = fv;
    exp_q.push_back(snapshot(ri));
    if (rst) model_reset();
    else     model_step(sv, si, rv, ri, fv);
  endtask

  task automatic idle(input int ri);
    step(1'b0, 1'b0, 8'h00, 1'b0, ri, 1'b0);
  endtask

  task automatic save(input logic [W-1:0] v);
    step(1'b0, 1'b1, v, 1'b0, 0, 1'b0);
  endtask

  // ---- scoreboard monitor ----
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    logic [21:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("save_ready", 8'(save_ready), 8'(e[12]));
      chk("save_index", 8'(save_index), 8'(e[11:9]));
      chk("free_index", 8'(free_index), 8'(e[8:6]));
      chk("occupancy",  8'(occupancy),  8'(e[5:3]));
      chk("empty",      8'(empty),      8'(e[2]));
      chk("full",       8'(full),       8'(e[1]));
      chk("error",      8'(error),      8'(e[0]));
      if (e[21]) chk("restore_info", restore_info, e[20:13]);
    end
  end

  // ---- stimulus ----
  initial begin
    foreach (seen[i]) seen[i] = 1'b0;
    model_reset();
    @(posedge CLK);

    // reset values, then reset mid-sequence after three saves
    idle(0);
    save(8'hA0); save(8'hA1); save(8'hA2);
    step(1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    idle(0);

    // fill, then overflow attempt; mem[0] must still hold 0x10
    for (int i = 0; i < N; i++) save(8'(8'h10 + i));
    save(8'h16);
    idle(0);

    // wrap: fresh reset, 6 saves, 2 frees, 2 more saves
    step(1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    for (int i = 0; i < N; i++) save(8'(8'h10 + i));
    step(1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1);
    save(8'h20); save(8'h21);
    idle(1);

    // rollback to 4 with a squashed save, then confirm mem[2] untouched
    step(1'b0, 1'b1, 8'h99, 1'b1, 4, 1'b0);
    idle(2);

    // restore at head with free in the same cycle
    step(1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1);
    idle(3);

    // non-live restore, then free from empty after reset
    save(8'h30); save(8'h31);
    step(1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    idle(0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1);
    idle(0);

    // randomized traffic with occasional reset
    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(0, 149) == 0,
           $urandom_range(0, 99) < 55,
           8'($urandom),
           $urandom_range(0, 99) < 8,
           $urandom_range(0, N - 1),
           $urandom_range(0, 99) < 35);
    end
    idle(0);

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
